// File: rtl/tgl_handshake_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : tgl_handshake_rx_if
//  Description : Bundle of the toggle-handshake signals between a toggle
//                sender, the tgl_handshake_rx receiver and the downstream
//                valid/ready consumer.
//                  req_tgl   - sender request toggle (one level change per word)
//                  data_in   - sender word, stable from req toggle to ack toggle
//                  ack_tgl   - receiver acknowledge toggle back to the sender
//                  data_out  - captured word presented to the consumer
//                  out_valid - data_out holds an unconsumed word
//                  out_ready - consumer accepts data_out when high with out_valid
//                Modport slave is the receiver view; master is the combined
//                sender/consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tgl_handshake_rx_if #(
   parameter int DATA_W = 8
);
   logic              req_tgl;
   logic [DATA_W-1:0] data_in;
   logic              ack_tgl;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  req_tgl,
      input  data_in,
      input  out_ready,
      output ack_tgl,
      output data_out,
      output out_valid
   );

   modport master (
      output req_tgl,
      output data_in,
      output out_ready,
      input  ack_tgl,
      input  data_out,
      input  out_valid
   );
endinterface
`default_nettype wire

// File: rtl/tgl_handshake_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tgl_handshake_rx
//  Description : Receiving end of a two-phase toggle handshake. Synchronizes
//                req_tgl, detects each level change, captures data_in, offers
//                it on a valid/ready port and returns a toggled ack_tgl once
//                the word is consumed. Also keeps a wrapping event counter and
//                a sticky overrun flag.
//  Ports       : clk          - rising-edge clock
//                rst          - synchronous active-high reset
//                hs           - handshake bundle (slave view): req_tgl,
//                               data_in, out_ready in; ack_tgl, data_out,
//                               out_valid out
//                overrun_clr  - single-cycle clear of overrun
//                event_count  - detected toggles, modulo 2^CNT_W
//                overrun      - sticky: toggle seen while a word was pending
//  Revision    : 1.0 - initial release
// ============================================================================
module tgl_handshake_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,   // must be >= 2
   parameter int CNT_W       = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   tgl_handshake_rx_if.slave      hs,
   input  wire logic              overrun_clr,
   output logic [CNT_W-1:0]       event_count,
   output logic                   overrun
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Synchronizer: bit 0 is the first stage, bit SYNC_STAGES-1 the last.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;
   logic                   req_seen;
   logic                   edge_det;

   state_t                 state_q;
   state_t                 state_d;
   logic                   capture;
   logic                   accept;
   logic                   ov_set;

   logic [DATA_W-1:0]      data_q;
   logic                   ack_q;

   assign sync_last = sync_q[SYNC_STAGES-1];
   // Any level change of the synchronized request is one transfer.
   assign edge_det  = sync_last ^ req_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         req_seen <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], hs.req_tgl};
         req_seen <= sync_last;
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      accept  = 1'b0;
      ov_set  = 1'b0;
      case (state_q)
         IDLE: begin
            // out_ready is ignored here, so a fresh word is always visible
            // for at least one cycle before it can be accepted.
            if (edge_det) begin
               capture = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (hs.out_ready) begin
               accept  = 1'b1;
               state_d = IDLE;
            end
            // A toggle while a word is pending is dropped and flagged, even
            // when the pending word is accepted in the same cycle.
            if (edge_det) begin
               ov_set = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: captured word, ack toggle, counter, overrun flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         ack_q       <= 1'b0;
         event_count <= '0;
         overrun     <= 1'b0;
      end else begin
         if (capture) begin
            data_q <= hs.data_in;
         end
         if (accept) begin
            ack_q <= ~ack_q;
         end
         if (edge_det) begin
            event_count <= event_count + CNT_ONE;
         end
         // Set has priority over a simultaneous clear.
         if (ov_set) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign hs.data_out  = data_q;
   assign hs.out_valid = (state_q == VALID);
   assign hs.ack_tgl   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_tgl_handshake_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tgl_handshake_rx
//  Description : Self-checking bench for tgl_handshake_rx. A behavioural
//                model (request history, pending word, ack, counter, overrun)
//                is advanced every rising edge and compared against the DUT
//                every falling edge. Directed scenarios add literal checks;
//                a randomized phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tgl_handshake_rx;

   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic overrun_clr = 1'b0;
   logic [CNT_W-1:0] event_count;
   logic overrun;

   tgl_handshake_rx_if #(.DATA_W(DATA_W)) hs ();

   tgl_handshake_rx #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hs          (hs),
      .overrun_clr (overrun_clr),
      .event_count (event_count),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   bit chk_en     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model. hist[0] is the request level sampled at the most
   // recent edge; a toggle is seen SYNC_STAGES+1 edges after the change.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES:0] hist = '0;
   bit               m_pending = 0;
   logic [DATA_W-1:0] m_word  = '0;
   bit               m_ack     = 0;
   int               m_count   = 0;
   bit               m_overrun = 0;

   always @(posedge clk) begin
      bit ev;
      bit was_pending;
      if (rst) begin
         hist      = '0;
         m_pending = 0;
         m_word    = '0;
         m_ack     = 0;
         m_count   = 0;
         m_overrun = 0;
      end else begin
         ev          = hist[SYNC_STAGES-1] ^ hist[SYNC_STAGES];
         was_pending = m_pending;
         if (was_pending && hs.out_ready) begin
            m_pending = 0;
            m_ack     = !m_ack;
         end
         if (ev && !was_pending) begin
            m_pending = 1;
            m_word    = hs.data_in;
         end
         if (ev) m_count = (m_count + 1) % (1 << CNT_W);
         if (ev && was_pending) m_overrun = 1;
         else if (overrun_clr)  m_overrun = 0;
         hist = {hist[SYNC_STAGES-1:0], hs.req_tgl};
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model out_valid",   {31'd0, hs.out_valid}, {31'd0, m_pending});
         check("model data_out",    {24'd0, hs.data_out},  {24'd0, m_word});
         check("model ack_tgl",     {31'd0, hs.ack_tgl},   {31'd0, m_ack});
         check("model event_count", {28'd0, event_count},  m_count);
         check("model overrun",     {31'd0, overrun},      {31'd0, m_overrun});
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (all driven on the falling edge)
   // ------------------------------------------------------------------
   task automatic send(input logic [DATA_W-1:0] d);
      @(negedge clk);
      hs.data_in = d;
      hs.req_tgl = ~hs.req_tgl;
   endtask

   task automatic wait_ack(input logic old_ack, input string name);
      int n = 0;
      while (hs.ack_tgl === old_ack && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, hs.ack_tgl}, {31'd0, ~old_ack});
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (hs.out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, hs.out_valid}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      hs.req_tgl = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst        = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic old;
      int   cnt;
      hs.req_tgl   = 1'b0;
      hs.data_in   = '0;
      hs.out_ready = 1'b0;

      // Reset state
      do_reset();
      check("reset out_valid", {31'd0, hs.out_valid}, 32'd0);
      check("reset ack_tgl",   {31'd0, hs.ack_tgl},   32'd0);
      check("reset data_out",  {24'd0, hs.data_out},  32'd0);
      check("reset count",     {28'd0, event_count},  32'd0);

      // Single transfer with out_ready held high: valid at 3rd falling edge
      hs.out_ready = 1'b1;
      send(8'hA5);
      @(negedge clk); check("t1 valid lat1", {31'd0, hs.out_valid}, 32'd0);
      @(negedge clk); check("t1 valid lat2", {31'd0, hs.out_valid}, 32'd0);
      @(negedge clk); check("t1 valid",      {31'd0, hs.out_valid}, 32'd1);
      check("t1 data", {24'd0, hs.data_out}, 32'hA5);
      check("t1 count", {28'd0, event_count}, 32'd1);
      @(negedge clk); check("t1 valid drop", {31'd0, hs.out_valid}, 32'd0);
      check("t1 ack", {31'd0, hs.ack_tgl}, 32'd1);
      check("t1 data hold", {24'd0, hs.data_out}, 32'hA5);

      // Backpressure: ready low 5 cycles after valid, then high
      hs.out_ready = 1'b0;
      old = hs.ack_tgl;
      send(8'h3C);
      wait_valid("bp valid timeout");
      cnt = 0;
      while (hs.out_valid === 1'b1 && cnt < 20) begin
         cnt++;
         check("bp data", {24'd0, hs.data_out}, 32'h3C);
         check("bp ack",  {31'd0, hs.ack_tgl},  {31'd0, old});
         if (cnt == 6) hs.out_ready = 1'b1;
         @(negedge clk);
      end
      check("bp valid width", cnt, 32'd6);
      check("bp ack after", {31'd0, hs.ack_tgl}, {31'd0, ~old});

      // Back-to-back transfers, each issued after the ack change
      do_reset();
      hs.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         old = hs.ack_tgl;
         send(i[DATA_W-1:0]);
         wait_ack(old, "b2b ack timeout");
      end
      check("b2b ack end",  {31'd0, hs.ack_tgl}, 32'd0);
      check("b2b count",    {28'd0, event_count}, 32'd4);
      check("b2b overrun",  {31'd0, overrun}, 32'd0);
      check("b2b last data", {24'd0, hs.data_out}, 32'h04);

      // Overrun: two toggles while ready is low
      do_reset();
      hs.out_ready = 1'b0;
      send(8'h11);
      repeat (6) @(negedge clk);
      send(8'h22);
      repeat (6) @(negedge clk);
      check("ov data",    {24'd0, hs.data_out}, 32'h11);
      check("ov flag",    {31'd0, overrun},     32'd1);
      check("ov count",   {28'd0, event_count}, 32'd2);
      check("ov ack",     {31'd0, hs.ack_tgl},  32'd0);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("ov cleared", {31'd0, overrun}, 32'd0);
      hs.out_ready = 1'b1;
      wait_ack(1'b0, "ov drain timeout");

      // Counter wrap: 17 transfers with a 4-bit counter
      do_reset();
      hs.out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         old = hs.ack_tgl;
         send(8'h40 + i[7:0]);
         wait_ack(old, "wrap ack timeout");
      end
      check("wrap count", {28'd0, event_count}, 32'd1);

      // Reset while a word is pending and ack is 1
      do_reset();
      hs.out_ready = 1'b1;
      send(8'h77);
      wait_ack(1'b0, "rm ack1 timeout");
      hs.out_ready = 1'b0;
      send(8'h88);
      wait_valid("rm valid timeout");
      rst        = 1'b1;
      hs.req_tgl = 1'b0;
      @(negedge clk);
      rst        = 1'b0;
      check("rm valid",   {31'd0, hs.out_valid}, 32'd0);
      check("rm ack",     {31'd0, hs.ack_tgl},   32'd0);
      check("rm data",    {24'd0, hs.data_out},  32'd0);
      check("rm count",   {28'd0, event_count},  32'd0);
      check("rm overrun", {31'd0, overrun},      32'd0);
      hs.out_ready = 1'b1;
      send(8'h5A);
      repeat (3) @(negedge clk);
      check("rm next valid", {31'd0, hs.out_valid}, 32'd1);
      check("rm next data",  {24'd0, hs.data_out},  32'h5A);
      wait_ack(1'b0, "rm next ack timeout");

      // Randomized phase: free-running toggles, backpressure, clears, resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         hs.out_ready = ($urandom_range(3) != 0);
         overrun_clr  = ($urandom_range(15) == 0);
         if ($urandom_range(199) == 0) begin
            rst        = 1'b1;
            hs.req_tgl = 1'b0;
         end else begin
            rst = 1'b0;
            if ($urandom_range(5) == 0) begin
               hs.data_in = DATA_W'($urandom);
               hs.req_tgl = ~hs.req_tgl;
            end
         end
      end
      @(negedge clk);
      rst = 1'b0;
      overrun_clr = 1'b0;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
